// File: rtl/wb_write_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Default widths, the late-result entry layout and the grant encoding.
package wb_write_arbiter_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_REG_BITS = 4;

  typedef struct packed {
    logic [DEF_REG_BITS-1:0] dest;
    logic [DEF_WIDTH-1:0]    value;
  } late_entry_t;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_PIPE = 2'd1;
  localparam logic [1:0] GNT_LATE = 2'd2;

endpackage

// File: rtl/wb_late_fifo.sv
// Circular buffer for late write-back results. Exposes per-entry valid bits
// and destinations so the top can build pending-destination hit flags.
module wb_late_fifo
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int REG_BITS = DEF_REG_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [REG_BITS-1:0]   push_dest,
  input  logic [WIDTH-1:0]      push_value,
  input  logic                  pop,
  output logic [REG_BITS-1:0]   head_dest,
  output logic [WIDTH-1:0]      head_value,
  output logic [$clog2(DEPTH):0] count,
  output logic                  full,
  output logic [DEPTH-1:0]      valid,
  output logic [REG_BITS-1:0]   dest_vec [DEPTH]
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [WIDTH-1:0] value_mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Full comes from the registered count only, so a same-cycle pop never frees a slot.
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);

  assign head_dest  = dest_vec[rd_ptr];
  assign head_value = value_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (do_pop) begin
        rd_ptr        <= rd_ptr + 1'b1;
        valid[rd_ptr] <= 1'b0;
      end
      if (do_push) begin
        wr_ptr        <= wr_ptr + 1'b1;
        valid[wr_ptr] <= 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; the valid bits alone decide what is meaningful.
  always_ff @(posedge clk) begin
    if (do_push) begin
      dest_vec[wr_ptr]  <= push_dest;
      value_mem[wr_ptr] <= push_value;
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline WB has priority, late results
// queue in a FIFO, and a starvation counter forces a one-cycle freeze to drain.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int REG_BITS = DEF_REG_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pipe_wb_en,
  input  logic [REG_BITS-1:0]    pipe_dest,
  input  logic [WIDTH-1:0]       pipe_value,
  input  logic                   late_valid,
  output logic                   late_ready,
  input  logic [REG_BITS-1:0]    late_dest,
  input  logic [WIDTH-1:0]       late_value,
  output logic                   rf_wr_en,
  output logic [REG_BITS-1:0]    rf_wr_dest,
  output logic [WIDTH-1:0]       rf_wr_value,
  output logic                   freeze,
  input  logic [REG_BITS-1:0]    chk_src1,
  input  logic [REG_BITS-1:0]    chk_src2,
  input  logic [REG_BITS-1:0]    chk_dst,
  output logic                   src1_hit,
  output logic                   src2_hit,
  output logic                   dst_hit,
  output logic [$clog2(DEPTH):0] count
);

  localparam int              WAIT_W    = $clog2(MAX_WAIT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  logic [1:0]          gnt;
  logic                pop;
  logic                full;
  logic [DEPTH-1:0]    valid;
  logic [REG_BITS-1:0] dest_vec [DEPTH];
  logic [REG_BITS-1:0] head_dest;
  logic [WIDTH-1:0]    head_value;
  logic [WAIT_W-1:0]   wait_cnt;

  wb_late_fifo #(
    .DEPTH    (DEPTH),
    .WIDTH    (WIDTH),
    .REG_BITS (REG_BITS)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (late_valid),
    .push_dest  (late_dest),
    .push_value (late_value),
    .pop        (pop),
    .head_dest  (head_dest),
    .head_value (head_value),
    .count      (count),
    .full       (full),
    .valid      (valid),
    .dest_vec   (dest_vec)
  );

  assign late_ready = !full;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    gnt = GNT_NONE;
    if (freeze)               gnt = GNT_LATE;
    else if (pipe_wb_en)      gnt = GNT_PIPE;
    else if (count != '0)     gnt = GNT_LATE;
  end

  assign pop         = (gnt == GNT_LATE);
  assign rf_wr_en    = rst && (gnt != GNT_NONE);
  assign rf_wr_dest  = (gnt == GNT_PIPE) ? pipe_dest  : head_dest;
  assign rf_wr_value = (gnt == GNT_PIPE) ? pipe_value : head_value;

  // A losing head that has already waited MAX_WAIT-1 cycles freezes the pipe next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      freeze   <= 1'b0;
    end else begin
      if (pop || count == '0) wait_cnt <= '0;
      else                    wait_cnt <= wait_cnt + 1'b1;
      freeze <= (count != '0) && !pop && (wait_cnt == WAIT_LAST);
    end
  end

  // Conservative hits: an entry popping this cycle still reports as pending.
  always_comb begin
    src1_hit = 1'b0;
    src2_hit = 1'b0;
    dst_hit  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i]) begin
        if (dest_vec[i] == chk_src1) src1_hit = 1'b1;
        if (dest_vec[i] == chk_src2) src2_hit = 1'b1;
        if (dest_vec[i] == chk_dst)  dst_hit  = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: directed scenarios plus a random
// phase, with a scoreboard queue of accepted late results checked on write-back.
module tb_wb_write_arbiter;
  import wb_write_arbiter_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        pipe_wb_en;
  logic [3:0]  pipe_dest;
  logic [31:0] pipe_value;
  logic        late_valid;
  logic        late_ready;
  logic [3:0]  late_dest;
  logic [31:0] late_value;
  logic        rf_wr_en;
  logic [3:0]  rf_wr_dest;
  logic [31:0] rf_wr_value;
  logic        freeze;
  logic [3:0]  chk_src1;
  logic [3:0]  chk_src2;
  logic [3:0]  chk_dst;
  logic        src1_hit;
  logic        src2_hit;
  logic        dst_hit;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  late_entry_t exp_q[$];

  wb_write_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(8), .WIDTH(32), .REG_BITS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .pipe_wb_en  (pipe_wb_en),
    .pipe_dest   (pipe_dest),
    .pipe_value  (pipe_value),
    .late_valid  (late_valid),
    .late_ready  (late_ready),
    .late_dest   (late_dest),
    .late_value  (late_value),
    .rf_wr_en    (rf_wr_en),
    .rf_wr_dest  (rf_wr_dest),
    .rf_wr_value (rf_wr_value),
    .freeze      (freeze),
    .chk_src1    (chk_src1),
    .chk_src2    (chk_src2),
    .chk_dst     (chk_dst),
    .src1_hit    (src1_hit),
    .src2_hit    (src2_hit),
    .dst_hit     (dst_hit),
    .count       (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: count, ready, hits and every write are checked against the queue.
  int          sz;
  logic        e_src1, e_src2, e_dst;
  late_entry_t ent;

  always @(negedge clk) begin
    if (mon_en) begin
      sz = exp_q.size();
      check("mon_count", count, sz);
      check("mon_late_ready", late_ready, sz < DEPTH);
      e_src1 = 1'b0; e_src2 = 1'b0; e_dst = 1'b0;
      foreach (exp_q[i]) begin
        if (exp_q[i].dest == chk_src1) e_src1 = 1'b1;
        if (exp_q[i].dest == chk_src2) e_src2 = 1'b1;
        if (exp_q[i].dest == chk_dst)  e_dst  = 1'b1;
      end
      check("mon_src1_hit", src1_hit, e_src1);
      check("mon_src2_hit", src2_hit, e_src2);
      check("mon_dst_hit", dst_hit, e_dst);
      check("mon_wr_en", rf_wr_en, pipe_wb_en || (sz > 0));
      if (rf_wr_en) begin
        if (pipe_wb_en && !freeze) begin
          check("mon_pipe_dest", rf_wr_dest, pipe_dest);
          check("mon_pipe_value", rf_wr_value, pipe_value);
        end else if (sz > 0) begin
          ent = exp_q.pop_front();
          check("mon_late_dest", rf_wr_dest, ent.dest);
          check("mon_late_value", rf_wr_value, ent.value);
        end else begin
          check("mon_freeze_empty", freeze, 1'b0);
        end
      end
      if (late_valid && sz < DEPTH) exp_q.push_back('{dest: late_dest, value: late_value});
    end
  end

  initial begin
    rst = 1'b0; pipe_wb_en = 1'b1; pipe_dest = 4'd2; pipe_value = 32'h1234;
    late_valid = 1'b1; late_dest = 4'd5; late_value = 32'h55;
    chk_src1 = 4'd5; chk_src2 = 4'd0; chk_dst = 4'd0;

    // 1. Reset state with requests asserted
    #12;
    check("rst_wr_en", rf_wr_en, 1'b0);
    check("rst_late_ready", late_ready, 1'b1);
    check("rst_count", count, 0);
    check("rst_freeze", freeze, 1'b0);
    check("rst_src1_hit", src1_hit, 1'b0);
    tick();
    rst = 1'b1; pipe_wb_en = 1'b0; mon_en = 1'b1;
    tick();
    late_valid = 1'b0;
    @(negedge clk);
    check("t1_count", count, 1);
    tick();

    // 2. Pipe only
    pipe_wb_en = 1'b1; pipe_dest = 4'd3; pipe_value = 32'h11;
    @(negedge clk);
    check("t2_wr_en", rf_wr_en, 1'b1);
    check("t2_dest", rf_wr_dest, 4'd3);
    check("t2_value", rf_wr_value, 32'h11);
    check("t2_count", count, 0);
    tick();
    pipe_wb_en = 1'b0;

    // 3. Late only, no bypass
    late_valid = 1'b1; late_dest = 4'd5; late_value = 32'hAA;
    @(negedge clk);
    check("t3_no_bypass", rf_wr_en, 1'b0);
    tick();
    late_valid = 1'b0;
    @(negedge clk);
    check("t3_wr_en", rf_wr_en, 1'b1);
    check("t3_dest", rf_wr_dest, 4'd5);
    check("t3_value", rf_wr_value, 32'hAA);
    tick();
    @(negedge clk);
    check("t3_count", count, 0);
    tick();

    // 4. Fill under pipe pressure, then hit flags
    pipe_wb_en = 1'b1; pipe_dest = 4'd8; pipe_value = 32'h88;
    for (int k = 1; k <= 4; k++) begin
      late_valid = 1'b1; late_dest = 4'(k); late_value = 32'h100 + 32'(k);
      tick();
    end
    late_dest = 4'd6; late_value = 32'h666;
    chk_src1 = 4'd3; chk_src2 = 4'd4; chk_dst = 4'd9;
    @(negedge clk);
    check("t4_ready", late_ready, 1'b0);
    check("t4_count", count, 4);
    check("t4_src1_hit", src1_hit, 1'b1);
    check("t4_src2_hit", src2_hit, 1'b1);
    check("t4_dst_hit", dst_hit, 1'b0);
    tick();
    @(negedge clk);
    check("t4_held_off", count, 4);
    tick();
    late_valid = 1'b0; pipe_wb_en = 1'b0;
    for (int k = 0; k < 6; k++) tick();

    // 5. Starvation freeze
    pipe_wb_en = 1'b1; pipe_dest = 4'd1; pipe_value = 32'h1111;
    late_valid = 1'b1; late_dest = 4'd7; late_value = 32'h77;
    tick();
    late_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t5_no_freeze", freeze, 1'b0);
      tick();
    end
    @(negedge clk);
    check("t5_freeze", freeze, 1'b1);
    check("t5_dest", rf_wr_dest, 4'd7);
    check("t5_value", rf_wr_value, 32'h77);
    tick();
    @(negedge clk);
    check("t5_freeze_clear", freeze, 1'b0);
    check("t5_pipe_dest", rf_wr_dest, 4'd1);
    check("t5_count", count, 0);
    tick();

    // 6. Async reset mid-operation
    late_valid = 1'b1; late_dest = 4'd10; late_value = 32'hA0;
    tick();
    late_dest = 4'd11; late_value = 32'hB0;
    tick();
    late_valid = 1'b0;
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    check("t6_count", count, 0);
    check("t6_wr_en", rf_wr_en, 1'b0);
    check("t6_freeze", freeze, 1'b0);
    check("t6_ready", late_ready, 1'b1);
    exp_q.delete();
    tick();
    rst = 1'b1; pipe_wb_en = 1'b0; mon_en = 1'b1;
    for (int k = 0; k < 6; k++) tick();

    // Random traffic, scoreboard-checked
    for (int k = 0; k < 400; k++) begin
      pipe_wb_en = ($urandom_range(0, 2) != 0);
      pipe_dest  = 4'($urandom);
      pipe_value = $urandom;
      late_valid = $urandom_range(0, 1) != 0;
      late_dest  = 4'($urandom);
      late_value = $urandom;
      chk_src1   = 4'($urandom);
      chk_src2   = 4'($urandom);
      chk_dst    = 4'($urandom);
      tick();
    end
    pipe_wb_en = 1'b0; late_valid = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    @(negedge clk);
    check("final_drained", count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Shares the single register-file write port between two writers: the in-order pipeline WB stage and a late-return port for multi-cycle results (SRAM loads, iterative multiply).
- The pipeline has priority. Late results wait in a small FIFO.
- A starvation counter raises a one-cycle pipeline freeze so queued results drain.
- Exposes pending-destination hit flags so the hazard unit can stall readers and writers of registers with an outstanding late write.

Parameters:
DEPTH, 4, late-result FIFO entries; power of two, >=2
MAX_WAIT, 8, consecutive cycles the FIFO head may lose arbitration before freeze; >=1
WIDTH, 32, data width
REG_BITS, 4, register index width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
pipe_wb_en  in  1  pipeline WB write request
pipe_dest  in  REG_BITS  pipeline destination register
pipe_value  in  WIDTH  pipeline write data
late_valid  in  1  late result offered
late_ready  out  1  FIFO can accept; equals not-full
late_dest  in  REG_BITS  late destination
late_value  in  WIDTH  late data
rf_wr_en  out  1  register-file write enable
rf_wr_dest  out  REG_BITS  register-file write index
rf_wr_value  out  WIDTH  register-file write data
freeze  out  1  registered stall request to pipeline (holds MEM/WB)
chk_src1  in  REG_BITS  ID-stage source 1
chk_src2  in  REG_BITS  ID-stage source 2
chk_dst  in  REG_BITS  ID-stage destination
src1_hit  out  1  chk_src1 matches a valid FIFO entry
src2_hit  out  1  chk_src2 matches a valid FIFO entry
dst_hit  out  1  chk_dst matches a valid FIFO entry
count  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
Reset (rst=0, asynchronous):
- count=0, read/write pointers=0, all valid bits=0, wait_cnt=0, freeze=0.
- rf_wr_en is forced 0 while rst=0. late_ready=1. All hit flags 0.

Arbitration (combinational, same cycle):
- freeze=1: FIFO head is granted and popped. pipe_wb_en is masked, and upstream re-presents the same entry next cycle.
- Otherwise, if pipe_wb_en=1: pipe is granted; rf_wr_* = pipe_*.
- Otherwise, if count>0: head is granted and popped; rf_wr_* = head entry.
- Otherwise: rf_wr_en=0. rf_wr_dest and rf_wr_value are don't-care; drive head contents.

Push:
- Occurs when late_valid & late_ready.
- Entry is written at tail; tail pointer wraps modulo DEPTH.
- No bypass: the earliest write of a pushed entry is the next cycle.
- late_ready = (count<DEPTH), from registered count only. No push occurs when full, even if a pop happens the same cycle.

Occupancy:
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Head pointer wraps modulo DEPTH.

Starvation:
- wait_cnt increments on each cycle with count>0 and no pop.
- wait_cnt clears on any pop, and when count=0.
- If wait_cnt==MAX_WAIT-1 and the head is not granted this cycle, freeze<=1 at the next edge.
- freeze stays high exactly one cycle, during which the head pops. freeze then clears and wait_cnt clears.
- With MAX_WAIT=8, freeze rises in the cycle after the 8th consecutive losing cycle.

Hit flags:
- Combinational compare of each chk_* input against the dest of every valid entry.
- Conservative: an entry popping this cycle still counts as a hit.
- The hazard unit stalls ID on any hit, which guarantees WAW/RAW ordering between late and pipe writes.

Invariants:
- At most one rf write per cycle.
- FIFO entries write back in push order.
- No entry is lost or duplicated across simultaneous push/pop/freeze.

Decomposition:
- Shared package holds:
  - WIDTH/REG_BITS defaults
  - late-entry struct {dest, value}
  - grant encoding constants GNT_NONE, GNT_PIPE, GNT_LATE
- One natural sub-module: wb_late_fifo. It is a parametric circular buffer with push/pop/count/per-entry valid and dest vectors, and it feeds the hit comparators.
- Arbitration, starvation counter and freeze register live in the top.

Test Plan:
1. Reset: rst=0 with late_valid=1, pipe_wb_en=1 -> rf_wr_en=0, late_ready=1, count=0, freeze=0. Release, push dest 5 -> count=1.
2. Pipe only: pipe_wb_en=1, dest=3, value=0x11 -> same cycle rf_wr_en=1, dest=3, value=0x11; count stays 0.
3. Late only: push dest=5, value=0xAA with pipe idle -> next cycle rf_wr dest=5, value=0xAA; then count=0.
4. Fill and hit: pipe_wb_en=1 held, push 4 entries (dests 1,2,3,4) -> late_ready=0 after the 4th, and a 5th valid is held off. chk_src1=3 -> src1_hit=1; chk_dst=9 -> dst_hit=0.
5. Starvation: pipe_wb_en=1 continuously, one entry queued (dest 7, 0x77), MAX_WAIT=8 -> freeze=1 in the cycle after 8 losing cycles. That cycle rf_wr dest=7, value=0x77 and pipe is masked. Next cycle freeze=0 and the pipe write proceeds.
6. Async reset mid-operation: 2 entries queued, drop rst between edges -> count=0, rf_wr_en=0, freeze=0 immediately. After release, no stale entry is ever written.
